// File: rtl/fetch_ram_1p_arb_pkg.sv
// fetch_ram_1p_arb_pkg: shared widths, requester indices and round-robin index helper
package fetch_ram_1p_arb_pkg;
  localparam int FETCH_RAM_ADDR_W = 5;
  localparam int FETCH_RAM_DATA_W = 128;
  typedef enum logic [1:0] {REQ_WR = 2'd0, REQ_RD0 = 2'd1, REQ_RD1 = 2'd2} req_idx_e;
  function automatic logic [1:0] rr_wrap(input logic [1:0] p, input int k);
    logic [2:0] s;
    s = 3'(p) + 3'(k);
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction
endpackage

// File: rtl/fetch_ram_1p_arb_if.sv
// fetch_ram_1p_arb_if: requester handshakes, read return and SRAM pins of the fetch RAM arbiter
interface fetch_ram_1p_arb_if
  import fetch_ram_1p_arb_pkg::*;
#(
  parameter int ADDR_W = FETCH_RAM_ADDR_W,
  parameter int DATA_W = FETCH_RAM_DATA_W
);
  logic              wr_req, wr_last, wr_gnt;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd0_req, rd0_last, rd0_gnt, rd0_val;
  logic [ADDR_W-1:0] rd0_addr;
  logic              rd1_req, rd1_last, rd1_gnt, rd1_val;
  logic [ADDR_W-1:0] rd1_addr;
  logic [DATA_W-1:0] rd_data;
  logic              ram_cen, ram_oen, ram_wen;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;
  modport slave (
    input  wr_req, wr_last, wr_addr, wr_data,
    input  rd0_req, rd0_last, rd0_addr, rd1_req, rd1_last, rd1_addr, ram_rdata,
    output wr_gnt, rd0_gnt, rd1_gnt, rd0_val, rd1_val, rd_data,
    output ram_cen, ram_oen, ram_wen, ram_addr, ram_wdata
  );
  modport master (
    output wr_req, wr_last, wr_addr, wr_data,
    output rd0_req, rd0_last, rd0_addr, rd1_req, rd1_last, rd1_addr, ram_rdata,
    input  wr_gnt, rd0_gnt, rd1_gnt, rd0_val, rd1_val, rd_data,
    input  ram_cen, ram_oen, ram_wen, ram_addr, ram_wdata
  );
endinterface

// File: rtl/fetch_ram_1p_arb_rr_pick3.sv
// fetch_rr_pick3: combinational 3-way round-robin picker, first requester at or after ptr wins
module fetch_rr_pick3
  import fetch_ram_1p_arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] gnt
);
  // scan from farthest to nearest so the nearest requester overwrites the others
  always_comb begin
    gnt = '0;
    for (int k = 2; k >= 0; k--) if (req[rr_wrap(ptr, k)]) gnt = 3'b001 << rr_wrap(ptr, k);
  end
endmodule

// File: rtl/fetch_ram_1p_arb.sv
// fetch_ram_1p_arb: round-robin locked-burst arbiter for one single-port fetch SRAM; FETCH_RAM_ARB_RDATA_REG_EN registers read data
module fetch_ram_1p_arb
  import fetch_ram_1p_arb_pkg::*;
#(
  parameter int ADDR_W    = FETCH_RAM_ADDR_W,
  parameter int DATA_W    = FETCH_RAM_DATA_W,
  parameter int MAX_BURST = 8
) (
  input logic              clk,
  input logic              rstn,
  fetch_ram_1p_arb_if.slave bus
);
  localparam int CW = $clog2(MAX_BURST + 1);
  logic [2:0]        req, rr_gnt, gnt;
  logic [1:0]        ptr, owner, gidx, pend, vals;
  logic              lock, any, rel, oen_q;
  logic [CW-1:0]     beat_cnt;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] rdata;
  assign req = {bus.rd1_req, bus.rd0_req, bus.wr_req};
  fetch_rr_pick3 u_pick (.req(req), .ptr(ptr), .gnt(rr_gnt));
  assign gnt      = rstn ? (lock ? req & (3'b001 << owner) : rr_gnt) : 3'b000;
  assign any      = |gnt;
  assign gidx     = gnt[2] ? REQ_RD1 : gnt[1] ? REQ_RD0 : REQ_WR;
  assign rel      = |(gnt & {bus.rd1_last, bus.rd0_last, bus.wr_last}) | (beat_cnt == CW'(MAX_BURST - 1));
  assign addr_sel = gnt[1] ? bus.rd0_addr : gnt[2] ? bus.rd1_addr : bus.wr_addr;
  assign bus.wr_gnt    = gnt[0];
  assign bus.rd0_gnt   = gnt[1];
  assign bus.rd1_gnt   = gnt[2];
  assign bus.ram_cen   = ~any;
  assign bus.ram_wen   = ~gnt[0];
  assign bus.ram_addr  = addr_sel;
  assign bus.ram_wdata = bus.wr_data;
  assign bus.ram_oen   = oen_q | ~rstn;
  assign bus.rd0_val   = vals[0] & rstn;
  assign bus.rd1_val   = vals[1] & rstn;
  assign bus.rd_data   = rdata;
  // burst lock, owner and beat counter; release rotates the pointer past the granted requester
  always_ff @(posedge clk)
    if (!rstn) begin
      ptr      <= REQ_WR;
      owner    <= REQ_WR;
      lock     <= 1'b0;
      beat_cnt <= '0;
    end else if (any) begin
      if (rel) begin
        lock     <= 1'b0;
        beat_cnt <= '0;
        ptr      <= rr_wrap(gidx, 1);
      end else begin
        lock     <= 1'b1;
        owner    <= gidx;
        beat_cnt <= beat_cnt + CW'(1);
      end
    end
  // track reads launched last cycle: they drive SRAM output enable and the return strobes
  always_ff @(posedge clk)
    if (!rstn) begin
      pend  <= '0;
      oen_q <= 1'b1;
    end else begin
      pend  <= gnt[2:1];
      oen_q <= ~(gnt[1] | gnt[2]);
    end
`ifdef FETCH_RAM_ARB_RDATA_REG_EN
  logic [1:0]        val_q;
  logic [DATA_W-1:0] rdata_q;
  // extra output stage: capture SRAM data and delay the strobes to match
  always_ff @(posedge clk)
    if (!rstn) begin
      val_q   <= '0;
      rdata_q <= '0;
    end else begin
      val_q   <= pend;
      rdata_q <= bus.ram_rdata;
    end
  assign vals  = val_q;
  assign rdata = rdata_q;
`else
  assign vals  = pend;
  assign rdata = bus.ram_rdata;
`endif
endmodule

// File: tb/tb_fetch_ram_1p_arb.sv
// tb_fetch_ram_1p_arb: vector table plus read-return scoreboard against an SRAM model
module tb_fetch_ram_1p_arb;
  import fetch_ram_1p_arb_pkg::*;
  localparam int AW = FETCH_RAM_ADDR_W;
  localparam int DW = FETCH_RAM_DATA_W;
`ifdef FETCH_RAM_ARB_RDATA_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  typedef struct {logic [2:0] req; logic [2:0] last; logic [2:0] gnt;} vec_t;
  typedef struct {int due; int who; logic [DW-1:0] data;} sb_t;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [DW-1:0] mem [32];
  logic [DW-1:0] shadow [32];
  logic [DW-1:0] rdq;
  sb_t sb [$];
  logic prev_rd = 1'b0;
  bit e0, e1;
  vec_t tv [26];
  logic v [1:5];
  logic [DW-1:0] d [1:5];
  always #5 clk = ~clk;
  fetch_ram_1p_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  fetch_ram_1p_arb #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(8)) dut (.clk(clk), .rstn(rstn), .bus(bus));
  function automatic logic [DW-1:0] init_word(int i);
    return DW'(32'hA0 + i);
  endfunction
  task automatic chk(string n, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  always @(posedge clk)
    if (!rstn) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_word(i);
      rdq <= '0;
    end else if (!bus.ram_cen) begin
      if (!bus.ram_wen) mem[bus.ram_addr] <= bus.ram_wdata;
      else rdq <= mem[bus.ram_addr];
    end
  assign bus.ram_rdata = rdq;
  always @(negedge clk) begin
    cyc++;
    if (!rstn) begin
      sb.delete();
      prev_rd = 1'b0;
      for (int i = 0; i < 32; i++) shadow[i] = init_word(i);
      chk("rst_outs", {bus.wr_gnt, bus.rd0_gnt, bus.rd1_gnt, bus.rd0_val, bus.rd1_val,
                       bus.ram_cen, bus.ram_wen, bus.ram_oen}, 8'b0000_0111);
    end else begin
      e0 = sb.size() > 0 && sb[0].due == cyc && sb[0].who == 0;
      e1 = sb.size() > 0 && sb[0].due == cyc && sb[0].who == 1;
      chk("val0", bus.rd0_val, e0);
      chk("val1", bus.rd1_val, e1);
      if (e0 || e1) begin
        chk("rdata", bus.rd_data, sb[0].data);
        sb.delete(0);
      end
      chk("oen", bus.ram_oen, !prev_rd);
      chk("onehot", $countones({bus.wr_gnt, bus.rd0_gnt, bus.rd1_gnt}) <= 1, 1'b1);
      chk("ram_ctl", {bus.ram_cen, bus.ram_wen},
          {!(bus.wr_gnt | bus.rd0_gnt | bus.rd1_gnt), !bus.wr_gnt});
      if (bus.wr_gnt | bus.rd0_gnt | bus.rd1_gnt)
        chk("ram_addr", bus.ram_addr, bus.wr_gnt ? bus.wr_addr : bus.rd0_gnt ? bus.rd0_addr : bus.rd1_addr);
      if (bus.wr_gnt) begin
        chk("ram_wdata", bus.ram_wdata, bus.wr_data);
        shadow[bus.wr_addr] = bus.wr_data;
      end
      if (bus.rd0_gnt) sb.push_back('{cyc + LAT, 0, shadow[bus.rd0_addr]});
      if (bus.rd1_gnt) sb.push_back('{cyc + LAT, 1, shadow[bus.rd1_addr]});
      prev_rd = bus.rd0_gnt | bus.rd1_gnt;
    end
  end
  task automatic set_req(logic [2:0] r, logic [2:0] l);
    {bus.rd1_req, bus.rd0_req, bus.wr_req}    = r;
    {bus.rd1_last, bus.rd0_last, bus.wr_last} = l;
    bus.wr_addr  = AW'($urandom);
    bus.rd0_addr = AW'($urandom);
    bus.rd1_addr = AW'($urandom);
    bus.wr_data  = {$urandom, $urandom, $urandom, $urandom};
  endtask
  task automatic drive(logic [2:0] r, logic [2:0] l);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    set_req(r, l);
  endtask
  task automatic reset_idle(int n);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    set_req(3'b000, 3'b000);
    repeat (n - 1) @(posedge clk);
  endtask
  task automatic gnt_chk(string n, logic [2:0] exp);
    @(negedge clk);
    chk(n, {bus.rd1_gnt, bus.rd0_gnt, bus.wr_gnt}, exp);
  endtask
  initial begin
    tv = '{
      '{3'b111, 3'b111, 3'b001}, '{3'b111, 3'b111, 3'b010}, '{3'b111, 3'b111, 3'b100},
      '{3'b111, 3'b111, 3'b001}, '{3'b111, 3'b111, 3'b010},
      '{3'b101, 3'b000, 3'b100}, '{3'b101, 3'b000, 3'b100},
      '{3'b001, 3'b000, 3'b000}, '{3'b001, 3'b000, 3'b000},
      '{3'b101, 3'b000, 3'b100}, '{3'b101, 3'b100, 3'b100},
      '{3'b011, 3'b000, 3'b001}, '{3'b011, 3'b000, 3'b001}, '{3'b011, 3'b000, 3'b001},
      '{3'b011, 3'b000, 3'b001}, '{3'b011, 3'b000, 3'b001}, '{3'b011, 3'b000, 3'b001},
      '{3'b011, 3'b000, 3'b001}, '{3'b011, 3'b000, 3'b001},
      '{3'b011, 3'b010, 3'b010}, '{3'b011, 3'b000, 3'b001}, '{3'b001, 3'b001, 3'b001},
      '{3'b110, 3'b110, 3'b010}, '{3'b011, 3'b011, 3'b001},
      '{3'b100, 3'b100, 3'b100}, '{3'b110, 3'b110, 3'b010}
    };
    set_req(3'b111, 3'b111);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_gnt", {bus.rd1_gnt, bus.rd0_gnt, bus.wr_gnt}, 3'b000);
      chk("rst_ram", {bus.ram_cen, bus.ram_wen, bus.ram_oen}, 3'b111);
      chk("rst_val", {bus.rd1_val, bus.rd0_val}, 2'b00);
    end
    drive(3'b111, 3'b111);
    gnt_chk("release_wr", 3'b001);
    reset_idle(2);
    for (int c = 1; c <= 5; c++) begin
      drive(c <= 2 ? 3'b010 : 3'b000, 3'b010);
      if (c == 1) bus.rd0_addr = 5'd3;
      if (c == 2) bus.rd0_addr = 5'd7;
      @(negedge clk);
      if (c <= 2) chk("rd_gnt", {bus.rd1_gnt, bus.rd0_gnt, bus.wr_gnt}, 3'b010);
      v[c] = bus.rd0_val;
      d[c] = bus.rd_data;
    end
    for (int c = 1; c <= 5; c++) chk($sformatf("rd_val_c%0d", c), v[c], c == 1 + LAT || c == 2 + LAT);
    chk("rd_data_a3", d[1 + LAT], 128'hA3);
    chk("rd_data_a7", d[2 + LAT], 128'hA7);
    reset_idle(2);
    for (int i = 0; i < 26; i++) begin
      drive(tv[i].req, tv[i].last);
      gnt_chk($sformatf("vec%0d", i), tv[i].gnt);
    end
    reset_idle(2);
    drive(3'b010, 3'b000);
    gnt_chk("burst_b1", 3'b010);
    drive(3'b011, 3'b000);
    gnt_chk("burst_b2", 3'b010);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    @(negedge clk);
    chk("mid_rst_val", bus.rd0_val, 1'b0);
    drive(3'b011, 3'b000);
    gnt_chk("post_rst_wr", 3'b001);
    chk("post_rst_val", bus.rd0_val, 1'b0);
    drive(3'b000, 3'b000);
    @(negedge clk);
    chk("post_rst_val2", bus.rd0_val, 1'b0);
    repeat (LAT + 2) drive(3'b000, 3'b000);
    @(negedge clk);
    chk("sb_drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
